// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and default widths for the memory port arbiter.
// Revision    : 1.0
// ============================================================================
package riscv_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_BE_WIDTH = DEF_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data and memory-side bundle around the arbiter.
// Revision    : 1.0
// ============================================================================
interface mem_port_arbiter_if import riscv_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int BE_WIDTH = DEF_BE_WIDTH
);

  logic                if_req;
  logic [WIDTH-1:0]    if_addr;
  logic [WIDTH-1:0]    if_rdata;
  logic                if_valid;
  logic                d_req;
  logic                d_we;
  logic [WIDTH-1:0]    d_addr;
  logic [WIDTH-1:0]    d_wdata;
  logic [BE_WIDTH-1:0] d_be;
  logic [WIDTH-1:0]    d_rdata;
  logic                d_valid;
  logic                err;
  logic                mem_req;
  logic                mem_we;
  logic [WIDTH-1:0]    mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [BE_WIDTH-1:0] mem_be;
  logic [WIDTH-1:0]    mem_rdata;
  logic                mem_ack;
  logic                busy;

  // Arbiter side: consumes core requests and memory responses.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ack,
    output if_rdata, if_valid, d_rdata, d_valid, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ack,
    input  if_rdata, if_valid, d_rdata, d_valid, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin fetch/data arbiter for one single-port memory,
//               with an acknowledge watchdog.
// Revision    : 1.0
// ============================================================================
module mem_port_arbiter import riscv_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int BE_WIDTH = DEF_BE_WIDTH,
  parameter int TIMEOUT  = 255
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mem_port_arbiter_if.slave bus
);

  localparam int                WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t          state_q, state_d;
  owner_t              last_q, last_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [BE_WIDTH-1:0] mem_be_q, mem_be_d;
  logic [WIDTH-1:0]    if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0]    d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= OWN_IF;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    wd_d        = wd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins when alone or when fetch owned the memory last time.
        if (bus.d_req && (!bus.if_req || last_q == OWN_IF)) begin
          state_d     = BUSY_D;
          last_d      = OWN_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_be_d    = bus.d_be;
        end else if (bus.if_req) begin
          state_d     = BUSY_IF;
          last_d      = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end
      end

      BUSY_IF, BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = bus.mem_rdata;
            end
          end
        end else if (wd_q == WD_LAST) begin
          // TIMEOUT-th cycle without an ack: abort, rdata untouched.
          state_d   = RESP;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
          end else begin
            d_valid_d = 1'b1;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
        wd_d    = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch port and the load/store data port of the RISC-V core.
- Registered request/acknowledge FSM with round-robin tie-break and an acknowledge watchdog.
- Sits between the core's fetch/data interfaces and the unified memory.
- Drives `busy` so the core controller can stall the PC and pipeline.

Parameters:
- WIDTH, 32, data and address width.
- BE_WIDTH, 4, byte-enable width (WIDTH/8).
- TIMEOUT, 255, maximum BUSY cycles waiting for mem_ack before abort; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request, level
- if_addr  input  WIDTH  fetch address
- if_rdata  output  WIDTH  fetched instruction
- if_valid  output  1  one-cycle fetch-complete pulse
- d_req  input  1  data request, level
- d_we  input  1  1 = store, 0 = load
- d_addr  input  WIDTH  data address
- d_wdata  input  WIDTH  store data
- d_be  input  BE_WIDTH  store byte enables
- d_rdata  output  WIDTH  load data
- d_valid  output  1  one-cycle data-complete pulse
- err  output  1  pulses with if_valid/d_valid when the access timed out
- mem_req  output  1  memory request, held until ack
- mem_we  output  1  memory write enable
- mem_addr  output  WIDTH  memory address
- mem_wdata  output  WIDTH  memory write data
- mem_be  output  BE_WIDTH  memory byte enables
- mem_rdata  input  WIDTH  memory read data
- mem_ack  input  1  memory completion, single-cycle
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE; last_owner = IF.
  - All outputs 0, including rdata registers; watchdog counter 0.
  - mem_req drops immediately. A memory transaction in flight is abandoned.
- States: IDLE, BUSY_IF, BUSY_D, RESP. All outputs are registered.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the port opposite last_owner. After reset, first contention goes to data.
  - On grant: latch addr, we, wdata and be into the mem_* registers and update last_owner.
  - Next state BUSY_IF or BUSY_D; mem_req = 1 from the next cycle.
  - Fetch grants drive mem_we = 0 and mem_be = all ones.
- BUSY_x:
  - mem_req held high with stable mem_* signals; watchdog increments each cycle.
  - mem_ack = 1: capture mem_rdata into the owner's rdata register, except for stores, where d_rdata is unchanged. Clear mem_req and go to RESP.
  - Watchdog reaches TIMEOUT with no ack: clear mem_req, leave rdata unchanged, set the err flag, go to RESP.
  - Ack in the same cycle as the timeout: the ack wins and err = 0.
- RESP:
  - Owner's valid = 1 for exactly one cycle; err = 1 in that cycle if the access timed out.
  - No arbitration takes place in RESP. Next state IDLE; watchdog cleared.
- Requester contract:
  - Hold req, addr, wdata and be stable from assertion until its valid pulse.
  - A req sampled high in IDLE is always a new request. A requester wanting no further access deasserts req in the valid cycle.
- Latency: grant edge → mem_req (cycle 1) → earliest ack in cycle 1 → valid in cycle 2 → IDLE in cycle 3. Minimum 3 cycles per access; back-to-back accesses are 3 cycles apart.
- mem_ack outside BUSY is ignored.
- rdata registers hold their value until the next completion for the same port.
- A request from the non-owner during BUSY/RESP waits; it is never lost or merged.
- Watchdog width is clog2(TIMEOUT+1); no wrap is possible because it clears in RESP.

Decomposition:
- Shared package riscv_pkg holds:
  - the arb_state_t enum (IDLE, BUSY_IF, BUSY_D, RESP);
  - the owner_t enum (OWN_IF, OWN_D);
  - the default WIDTH/BE_WIDTH constants.
- Single module; no sub-module. The watchdog is an inline counter.

Test Plan:
- Reset, then if_req=1 with if_addr=0x0000_0010; memory acks 1 cycle after mem_req with 0x0050_0093 → mem_addr=0x10 and mem_we=0; if_valid pulses in cycle 2 with if_rdata=0x0050_0093; busy falls in cycle 3.
- if_req and d_req rise together after reset, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_be=4'b0011 → data granted first with mem_be=0011 and d_rdata unchanged; fetch granted in the IDLE after d_valid.
- Both reqs held continuously for 4 accesses → grants alternate D, IF, D, IF; each valid is exactly one cycle; valids are 3 cycles apart.
- Load with memory ack delayed 7 cycles → mem_req stays high 7 cycles with stable mem_addr; d_valid pulses once; err=0.
- TIMEOUT=4, memory never acks → mem_req drops after 4 BUSY cycles; d_valid=1 and err=1 in the same cycle; previous d_rdata is retained.
- rst asserted low mid-BUSY_D → mem_req, busy and valid go 0 without waiting for clk. After release, a pending if_req is granted cleanly and a stray mem_ack in IDLE has no effect.
